// File: rtl/mandelbrot_frame_scheduler.sv
// Raster-order pixel sequencer for one Mandelbrot frame.
// Keeps one pixel in flight between the calculator and the frame buffer.
module mandelbrot_frame_scheduler #(
  parameter int          H_ACTIVE = 64,
  parameter int          V_ACTIVE = 48,
  parameter logic [31:0] X_MIN    = 32'hFE000000,
  parameter logic [31:0] X_STEP   = 32'h000C0000,
  parameter logic [31:0] Y_MIN    = 32'hFF000000,
  parameter logic [31:0] Y_STEP   = 32'h000AAAAA,
  parameter int          AW       = $clog2(H_ACTIVE*V_ACTIVE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_start,
  input  logic          abort,
  output logic          busy,
  output logic          frame_done,
  input  logic          calc_rdy,
  output logic          calc_start,
  output logic [31:0]   calc_real,
  output logic [31:0]   calc_imag,
  input  logic          calc_out_rdy,
  input  logic [31:0]   calc_colour,
  output logic          fb_we,
  input  logic          fb_ready,
  output logic [AW-1:0] fb_addr,
  output logic [8:0]    fb_data
);

  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    WRITE,
    DONE
  } state_e;

  state_e          state_q;
  logic [XW-1:0]   x_q;
  logic [YW-1:0]   y_q;
  logic [AW-1:0]   addr_q;
  logic [31:0]     real_q;
  logic [31:0]     imag_q;
  logic [8:0]      data_q;
  logic            busy_q;
  logic            done_q;
  logic            we_q;

  logic            last_px_d;
  logic            wr_acc_d;
  logic [8:0]      sat_d;

  assign last_px_d = (x_q == X_LAST) && (y_q == Y_LAST);
  assign wr_acc_d  = we_q && fb_ready;
  assign sat_d     = (calc_colour > 32'd511) ? 9'h1FF
                                             : calc_colour[8:0];

  // Start pulse is qualified in the same cycle the calculator reports ready.
  assign calc_start = (state_q == ISSUE) && calc_rdy
                   && !abort && !reset;

  assign busy       = busy_q;
  assign frame_done = done_q;
  assign calc_real  = real_q;
  assign calc_imag  = imag_q;
  assign fb_we      = we_q;
  assign fb_addr    = addr_q;
  assign fb_data    = data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= '0;
      real_q  <= X_MIN;
      imag_q  <= Y_MIN;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
    end else if (abort && (state_q != IDLE)) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (frame_start) begin
            state_q <= ISSUE;
            busy_q  <= 1'b1;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            real_q  <= X_MIN;
            imag_q  <= Y_MIN;
          end
        end
        ISSUE: begin
          if (calc_rdy) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (calc_out_rdy) begin
            data_q  <= sat_d;
            we_q    <= 1'b1;
            state_q <= WRITE;
          end
        end
        WRITE: begin
          if (wr_acc_d) begin
            we_q <= 1'b0;
            if (last_px_d) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= ISSUE;
              addr_q  <= addr_q + AW'(1);
              if (x_q != X_LAST) begin
                x_q    <= x_q + XW'(1);
                real_q <= real_q + X_STEP;
              end else begin
                x_q    <= '0;
                y_q    <= y_q + YW'(1);
                real_q <= X_MIN;
                imag_q <= imag_q + Y_STEP;
              end
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
